// File: rtl/ysyx_23060187_muldiv_pkg.sv
// ysyx_23060187_muldiv_pkg
//  Shared types and constants for the RV32M multiply/divide unit.
//  XLEN_DEFAULT : default operand/result width
//  state_e      : unit FSM states (IDLE, BUSY, DONE)
//  op_e         : internal op code after strobe priority resolution
//  DIV_ZERO_Q   : quotient returned for division by zero
//  sel_op       : priority encoder mul > mulh > div > divu > rem > remu
package ysyx_23060187_muldiv_pkg;

  localparam int XLEN_DEFAULT = 32;

  localparam logic [XLEN_DEFAULT-1:0] DIV_ZERO_Q = {XLEN_DEFAULT{1'b1}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  typedef enum logic [2:0] {
    OP_MUL  = 3'd0,
    OP_MULH = 3'd1,
    OP_DIV  = 3'd2,
    OP_DIVU = 3'd3,
    OP_REM  = 3'd4,
    OP_REMU = 3'd5,
    OP_NONE = 3'd6
  } op_e;

  // Multi-hot strobes collapse to the highest-priority op; no strobe gives OP_NONE.
  function automatic op_e sel_op(input logic mul, input logic mulh, input logic div,
                                 input logic divu, input logic rem, input logic remu);
    if (mul)       return OP_MUL;
    else if (mulh) return OP_MULH;
    else if (div)  return OP_DIV;
    else if (divu) return OP_DIVU;
    else if (rem)  return OP_REM;
    else if (remu) return OP_REMU;
    else           return OP_NONE;
  endfunction

endpackage

// File: rtl/ysyx_23060187_muldiv_divcore.sv
// ysyx_23060187_divcore
//  Restoring unsigned divider datapath: one quotient bit per enabled cycle.
//  Ports:
//   clk, rst          : clock, synchronous active-high reset
//   load              : capture dividend/divisor, clear partial remainder
//   en                : perform one restoring step
//   dividend, divisor : unsigned magnitudes
//   quot_nxt, rem_nxt : quotient/remainder after the current step (combinational),
//                       so the caller can capture the final answer on the last step edge
module ysyx_23060187_divcore
  import ysyx_23060187_muldiv_pkg::*;
#(
  parameter int XLEN = XLEN_DEFAULT
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            load,
  input  logic            en,
  input  logic [XLEN-1:0] dividend,
  input  logic [XLEN-1:0] divisor,
  output logic [XLEN-1:0] quot_nxt,
  output logic [XLEN-1:0] rem_nxt
);

  logic [XLEN-1:0] quot_r;
  logic [XLEN-1:0] rem_r;
  logic [XLEN-1:0] dvsr_r;
  logic [XLEN:0]   shift_s;
  logic [XLEN:0]   diff_s;

  // One restoring step: shift in the next dividend bit, subtract if it fits.
  // rem_r < dvsr_r always holds, so the difference fits back in XLEN bits.
  always_comb begin
    shift_s = {rem_r, quot_r[XLEN-1]};
    diff_s  = shift_s - {1'b0, dvsr_r};
    if (diff_s[XLEN]) begin
      rem_nxt  = shift_s[XLEN-1:0];
      quot_nxt = {quot_r[XLEN-2:0], 1'b0};
    end else begin
      rem_nxt  = diff_s[XLEN-1:0];
      quot_nxt = {quot_r[XLEN-2:0], 1'b1};
    end
  end

  // Quotient register starts as the dividend and fills with quotient bits from the right.
  always_ff @(posedge clk) begin
    if (rst) begin
      quot_r <= {XLEN{1'b0}};
      rem_r  <= {XLEN{1'b0}};
      dvsr_r <= {XLEN{1'b0}};
    end else if (load) begin
      quot_r <= dividend;
      rem_r  <= {XLEN{1'b0}};
      dvsr_r <= divisor;
    end else if (en) begin
      quot_r <= quot_nxt;
      rem_r  <= rem_nxt;
    end
  end

endmodule

// File: rtl/ysyx_23060187_muldiv.sv
// ysyx_23060187_muldiv
//  Iterative RV32M multiply/divide unit with valid/ready handshakes.
//  Ports:
//   clk, rst                  : clock, synchronous active-high reset
//   in_valid / in_ready       : operand handshake (in_ready high only in IDLE)
//   op_mul..op_remu           : decoded strobes, resolved by priority
//   src1, src2                : rs1 / rs2 values
//   out_valid / out_ready     : result handshake, result held until taken
//   result                    : XLEN result
//  Build option YSYX_23060187_FAST_MUL_EN: mul/mulh complete through a single
//  combinational multiplier in one cycle; otherwise a 32-step shift-add is used.
module ysyx_23060187_muldiv
  import ysyx_23060187_muldiv_pkg::*;
#(
  parameter int XLEN = XLEN_DEFAULT
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic            op_mul,
  input  logic            op_mulh,
  input  logic            op_div,
  input  logic            op_divu,
  input  logic            op_rem,
  input  logic            op_remu,
  input  logic [XLEN-1:0] src1,
  input  logic [XLEN-1:0] src2,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result
);

  localparam int CNT_W = $clog2(XLEN);
  localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

  state_e            state_r;
  op_e               op_r;
  op_e               op_s;
  logic [CNT_W-1:0]  cnt_r;
  logic              in_ready_r;
  logic              out_valid_r;
  logic [XLEN-1:0]   result_r;
  logic              neg_p_r;
  logic              neg_q_r;
  logic              neg_rem_r;
  logic [2*XLEN-1:0] mcand_r;
  logic [2*XLEN-1:0] prod_r;
  logic [XLEN-1:0]   mplier_r;
  logic [2*XLEN-1:0] prod_nxt_s;
  logic [2*XLEN-1:0] prod_fix_s;
  logic              signed_div_s;
  logic              signed_mul_s;
  logic [XLEN-1:0]   a_mag_s;
  logic [XLEN-1:0]   b_mag_s;
  logic              fast_hit_s;
  logic [XLEN-1:0]   fast_res_s;
  logic [XLEN-1:0]   quot_nxt_s;
  logic [XLEN-1:0]   rem_nxt_s;
  logic [XLEN-1:0]   quot_fix_s;
  logic [XLEN-1:0]   rem_fix_s;
  logic [XLEN-1:0]   final_s;
  logic              accept_s;
  logic              div_en_s;
`ifdef YSYX_23060187_FAST_MUL_EN
  logic [2*XLEN-1:0] full_prod_s;
`endif

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign result    = result_r;
  assign accept_s  = in_valid & in_ready_r;
  assign div_en_s  = (state_r == BUSY);

  // Resolve the op and take magnitudes; mul keeps raw bits since its low half is sign-agnostic.
  always_comb begin
    op_s         = sel_op(op_mul, op_mulh, op_div, op_divu, op_rem, op_remu);
    signed_div_s = (op_s == OP_DIV) || (op_s == OP_REM);
    signed_mul_s = (op_s == OP_MULH);
    if ((signed_div_s || signed_mul_s) && src1[XLEN-1]) begin
      a_mag_s = -src1;
    end else begin
      a_mag_s = src1;
    end
    if ((signed_div_s || signed_mul_s) && src2[XLEN-1]) begin
      b_mag_s = -src2;
    end else begin
      b_mag_s = src2;
    end
  end

`ifdef YSYX_23060187_FAST_MUL_EN
  // Sign-extended operands make the low 2*XLEN product bits the signed product.
  always_comb begin
    full_prod_s = {{XLEN{src1[XLEN-1]}}, src1} * {{XLEN{src2[XLEN-1]}}, src2};
  end
`endif

  // Cases that finish on the acceptance edge without iterating.
  always_comb begin
    fast_hit_s = 1'b0;
    fast_res_s = {XLEN{1'b0}};
    case (op_s)
      OP_DIV, OP_DIVU: begin
        if (src2 == {XLEN{1'b0}}) begin
          fast_hit_s = 1'b1;
          fast_res_s = DIV_ZERO_Q;
        end else if ((op_s == OP_DIV) && (src1 == INT_MIN) && (src2 == {XLEN{1'b1}})) begin
          fast_hit_s = 1'b1;
          fast_res_s = INT_MIN;
        end else begin
          fast_hit_s = 1'b0;
        end
      end
      OP_REM, OP_REMU: begin
        if (src2 == {XLEN{1'b0}}) begin
          fast_hit_s = 1'b1;
          fast_res_s = src1;
        end else if ((op_s == OP_REM) && (src1 == INT_MIN) && (src2 == {XLEN{1'b1}})) begin
          fast_hit_s = 1'b1;
          fast_res_s = {XLEN{1'b0}};
        end else begin
          fast_hit_s = 1'b0;
        end
      end
      OP_NONE: fast_hit_s = 1'b1;
`ifdef YSYX_23060187_FAST_MUL_EN
      OP_MUL: begin
        fast_hit_s = 1'b1;
        fast_res_s = full_prod_s[XLEN-1:0];
      end
      OP_MULH: begin
        fast_hit_s = 1'b1;
        fast_res_s = full_prod_s[2*XLEN-1:XLEN];
      end
`endif
      default: fast_hit_s = 1'b0;
    endcase
  end

  ysyx_23060187_divcore #(.XLEN(XLEN)) u_divcore (
    .clk      (clk),
    .rst      (rst),
    .load     (accept_s),
    .en       (div_en_s),
    .dividend (a_mag_s),
    .divisor  (b_mag_s),
    .quot_nxt (quot_nxt_s),
    .rem_nxt  (rem_nxt_s)
  );

  // Next shift-add partial product plus sign fix-up of whichever answer is being finished.
  always_comb begin
    if (mplier_r[0]) begin
      prod_nxt_s = prod_r + mcand_r;
    end else begin
      prod_nxt_s = prod_r;
    end
    if (neg_p_r) begin
      prod_fix_s = -prod_nxt_s;
    end else begin
      prod_fix_s = prod_nxt_s;
    end
    if (neg_q_r) begin
      quot_fix_s = -quot_nxt_s;
    end else begin
      quot_fix_s = quot_nxt_s;
    end
    if (neg_rem_r) begin
      rem_fix_s = -rem_nxt_s;
    end else begin
      rem_fix_s = rem_nxt_s;
    end
    case (op_r)
      OP_MUL:  final_s = prod_nxt_s[XLEN-1:0];
      OP_MULH: final_s = prod_fix_s[2*XLEN-1:XLEN];
      OP_DIV,
      OP_DIVU: final_s = quot_fix_s;
      OP_REM,
      OP_REMU: final_s = rem_fix_s;
      default: final_s = {XLEN{1'b0}};
    endcase
  end

  // Unit FSM: accept in IDLE, iterate XLEN steps in BUSY, hold the result in DONE.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= IDLE;
      op_r        <= OP_NONE;
      cnt_r       <= {CNT_W{1'b0}};
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
      result_r    <= {XLEN{1'b0}};
      neg_p_r     <= 1'b0;
      neg_q_r     <= 1'b0;
      neg_rem_r   <= 1'b0;
      mcand_r     <= {(2*XLEN){1'b0}};
      prod_r      <= {(2*XLEN){1'b0}};
      mplier_r    <= {XLEN{1'b0}};
    end else begin
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            op_r       <= op_s;
            cnt_r      <= {CNT_W{1'b0}};
            in_ready_r <= 1'b0;
            mcand_r    <= {{XLEN{1'b0}}, a_mag_s};
            mplier_r   <= b_mag_s;
            prod_r     <= {(2*XLEN){1'b0}};
            neg_p_r    <= signed_mul_s & (src1[XLEN-1] ^ src2[XLEN-1]);
            neg_q_r    <= signed_div_s & (src1[XLEN-1] ^ src2[XLEN-1]);
            neg_rem_r  <= signed_div_s & src1[XLEN-1];
            if (fast_hit_s) begin
              state_r     <= DONE;
              out_valid_r <= 1'b1;
              result_r    <= fast_res_s;
            end else begin
              state_r <= BUSY;
            end
          end
        end
        BUSY: begin
          prod_r   <= prod_nxt_s;
          mcand_r  <= {mcand_r[2*XLEN-2:0], 1'b0};
          mplier_r <= {1'b0, mplier_r[XLEN-1:1]};
          cnt_r    <= cnt_r + CNT_W'(1);
          if (cnt_r == CNT_W'(XLEN-1)) begin
            state_r     <= DONE;
            out_valid_r <= 1'b1;
            result_r    <= final_s;
          end
        end
        DONE: begin
          if (out_ready) begin
            state_r     <= IDLE;
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
          end
        end
        default: begin
          state_r     <= IDLE;
          out_valid_r <= 1'b0;
          in_ready_r  <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ysyx_23060187_muldiv.sv
// tb_ysyx_23060187_muldiv
//  Self-checking bench: directed RV32M cases plus randomized ops, each checked against an
//  arithmetic reference model. Honors YSYX_23060187_FAST_MUL_EN for expected mul latency.
module tb_ysyx_23060187_muldiv;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic        op_mul, op_mulh, op_div, op_divu, op_rem, op_remu;
  logic [31:0] src1, src2;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [31:0] exp_res = 32'd0;

  ysyx_23060187_muldiv dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op_mul    (op_mul),
    .op_mulh   (op_mulh),
    .op_div    (op_div),
    .op_divu   (op_divu),
    .op_rem    (op_rem),
    .op_remu   (op_remu),
    .src1      (src1),
    .src2      (src2),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Strobe vector: bit0 mul, bit1 mulh, bit2 div, bit3 divu, bit4 rem, bit5 remu.
  task automatic set_ops(input logic [5:0] s);
    {op_remu, op_rem, op_divu, op_div, op_mulh, op_mul} = s;
  endtask

  function automatic int first_op(input logic [5:0] s);
    int k;
    k = -1;
    for (int i = 5; i >= 0; i--) if (s[i]) k = i;
    return k;
  endfunction

  function automatic logic [31:0] model(input logic [5:0] s, input logic [31:0] a,
                                        input logic [31:0] b);
    longint      sa, sb;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (first_op(s))
      0: begin p = {32'd0, a} * {32'd0, b}; return p[31:0]; end
      1: begin p = sa * sb; return p[63:32]; end
      2: if (b == 32'd0) return 32'hFFFFFFFF; else begin p = sa / sb; return p[31:0]; end
      3: if (b == 32'd0) return 32'hFFFFFFFF; else return a / b;
      4: if (b == 32'd0) return a; else begin p = sa % sb; return p[31:0]; end
      5: if (b == 32'd0) return a; else return a % b;
      default: return 32'd0;
    endcase
  endfunction

  // Edges after acceptance until DONE: 0 for single-cycle cases, 32 for iterative ones.
  function automatic int model_delay(input logic [5:0] s, input logic [31:0] a,
                                     input logic [31:0] b);
    int k;
    k = first_op(s);
    if (k < 0) return 0;
    if (k >= 2 && b == 32'd0) return 0;
    if ((k == 2 || k == 4) && a == 32'h80000000 && b == 32'hFFFFFFFF) return 0;
`ifdef YSYX_23060187_FAST_MUL_EN
    if (k <= 1) return 0;
`endif
    return 32;
  endfunction

  // Compare process: whenever a result is presented it must equal the model's answer.
  always @(posedge clk) begin
    #1;
    if (out_valid === 1'b1) begin
      check("result_vs_model", result, exp_res);
      check("in_ready_low_in_done", 32'(in_ready), 32'd0);
    end
  end

  task automatic run_op(input logic [5:0] s, input logic [31:0] a, input logic [31:0] b,
                        input int hold);
    int d;
    exp_res = model(s, a, b);
    @(negedge clk);
    set_ops(s);
    src1      = a;
    src2      = b;
    in_valid  = 1'b1;
    out_ready = 1'b0;
    check("in_ready_idle", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    // Scramble inputs after acceptance: the unit must have latched them.
    in_valid = 1'b0;
    set_ops(6'($urandom));
    src1 = $urandom;
    src2 = $urandom;
    d = 0;
    while (out_valid !== 1'b1 && d < 100) begin
      @(posedge clk);
      #1;
      d++;
    end
    check("latency", 32'(d), 32'(model_delay(s, a, b)));
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      set_ops(6'b000100);
      src1 = $urandom;
      @(posedge clk);
      #1;
      check("done_hold_valid", 32'(out_valid), 32'd1);
      check("done_hold_result", result, exp_res);
    end
    @(negedge clk);
    out_ready = 1'b1;
    in_valid  = (hold > 0);
    @(posedge clk);
    #1;
    check("handoff_out_valid", 32'(out_valid), 32'd0);
    check("handoff_in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    out_ready = 1'b0;
    in_valid  = 1'b0;
  endtask

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 7))
      0: return 32'd0;
      1: return 32'hFFFFFFFF;
      2: return 32'h80000000;
      3: return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    logic [5:0] s;
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    src1      = 32'd0;
    src2      = 32'd0;
    set_ops(6'd0);
    repeat (2) @(posedge clk);
    #1;
    check("reset_in_ready", 32'(in_ready), 32'd1);
    check("reset_out_valid", 32'(out_valid), 32'd0);
    check("reset_result", result, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Hand-computed values pin the model itself.
    check("model_mul", model(6'b000001, 32'd7, 32'hFFFFFFFD), 32'hFFFFFFEB);
    check("model_mulh", model(6'b000010, 32'h80000000, 32'h80000000), 32'h40000000);
    check("model_div", model(6'b000100, 32'hFFFFFFF9, 32'd2), 32'hFFFFFFFD);
    check("model_rem", model(6'b010000, 32'hFFFFFFF9, 32'd2), 32'hFFFFFFFF);
    check("model_divu", model(6'b001000, 32'hFFFFFFFF, 32'd2), 32'h7FFFFFFF);
    check("model_remu", model(6'b100000, 32'hFFFFFFFF, 32'd2), 32'd1);
    check("model_div0", model(6'b000100, 32'd5, 32'd0), 32'hFFFFFFFF);
    check("model_rem0", model(6'b010000, 32'd5, 32'd0), 32'd5);
    check("model_ovf_div", model(6'b000100, 32'h80000000, 32'hFFFFFFFF), 32'h80000000);
    check("model_ovf_rem", model(6'b010000, 32'h80000000, 32'hFFFFFFFF), 32'd0);

    // Directed cases through the DUT.
    run_op(6'b000001, 32'd7, 32'hFFFFFFFD, 1);
    run_op(6'b000010, 32'h80000000, 32'h80000000, 0);
    run_op(6'b000100, 32'hFFFFFFF9, 32'd2, 0);
    run_op(6'b010000, 32'hFFFFFFF9, 32'd2, 0);
    run_op(6'b001000, 32'hFFFFFFFF, 32'd2, 0);
    run_op(6'b100000, 32'hFFFFFFFF, 32'd2, 0);
    run_op(6'b000100, 32'd5, 32'd0, 0);
    run_op(6'b010000, 32'd5, 32'd0, 0);
    run_op(6'b000100, 32'h80000000, 32'hFFFFFFFF, 0);
    run_op(6'b010000, 32'h80000000, 32'hFFFFFFFF, 0);
    run_op(6'b000000, 32'd9, 32'd3, 0);
    run_op(6'b110100, 32'd100, 32'd7, 10);

    // Reset during BUSY drops the pending result.
    exp_res = model(6'b000100, 32'd1000, 32'd3);
    @(negedge clk);
    set_ops(6'b000100);
    src1     = 32'd1000;
    src2     = 32'd3;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (15) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("midbusy_rst_in_ready", 32'(in_ready), 32'd1);
    check("midbusy_rst_out_valid", 32'(out_valid), 32'd0);
    check("midbusy_rst_result", result, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    run_op(6'b000001, 32'd12345, 32'd678, 0);

    // Randomized ops, including multi-hot and empty strobe sets.
    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(0, 3) == 0) s = 6'($urandom);
      else s = 6'(1 << $urandom_range(0, 5));
      run_op(s, pick_operand(), pick_operand(), int'($urandom_range(0, 2)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
